// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with one registered output stage
// and forwarding of the in-flight write onto both read ports.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  input  logic [ADDR_W-1:0]           rd_addr1,
  input  logic [ADDR_W-1:0]           rd_addr2,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2,
  output logic [DATA_W-1:0]           fwd_rdata1,
  output logic [DATA_W-1:0]           fwd_rdata2,
  output logic [15:0]                 conflict_cnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              grant;
  logic              take;
  logic              contention;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : arbitrate
    logic [PTR_W-1:0] idx;
    grant     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if ((32'(rr_ptr) + k) >= NUM_REQ) idx = PTR_W'(32'(rr_ptr) + k - NUM_REQ);
      else                              idx = PTR_W'(32'(rr_ptr) + k);
      if (!grant && req_valid[idx]) begin
        grant     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    take       = grant && !reset;
    req_ready  = take ? (NUM_REQ'(1) << grant_idx) : '0;
    next_ptr   = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    win_addr   = req_addr[grant_idx*ADDR_W +: ADDR_W];
    win_data   = req_data[grant_idx*DATA_W +: DATA_W];
    contention = $countones(req_valid) >= 2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_we <= 1'b0;
      if (take) begin
        rr_ptr   <= next_ptr;
        rf_we    <= (win_addr != '0);
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
      if (contention && conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Bypass the write that the register file has not committed yet.
  always_comb begin
    fwd_rdata1 = (rf_we && rf_waddr == rd_addr1 && rd_addr1 != '0) ? rf_wdata : rf_rdata1;
    fwd_rdata2 = (rf_we && rf_waddr == rd_addr2 && rd_addr2 != '0) ? rf_wdata : rf_rdata2;
  end

endmodule
